sigma_delta_dac: RTL and testbench

Downstream output stage for the sine generator: accepts its 16-bit sample stream, applied on each sample strobe, and drives a 1-bit pulse-density output pin through a sigma-delta modulator. The 1-bit pin feeds an external RC low-pass filter. A soft-mute gain ramp suppresses clicks. A gap watchdog holds the last sample and flags underrun when the strobe stops. Runs in the 10 MHz system clock domain.

---
 rtl/sigma_delta_dac_pkg.sv | 28 ++
 rtl/sigma_delta_dac_integrator.sv | 27 ++
 rtl/sigma_delta_dac.sv | 121 ++++++++++++
 tb/tb_sigma_delta_dac.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_dac_pkg.sv
// Shared types, constants and the integrator saturation helper for sigma_delta_dac.
package sigma_delta_dac_pkg;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      PLAY      = 2'd2,
      RAMP_DOWN = 2'd3
   } state_e;

   localparam int GAIN_MAX = 256;
   localparam int INT_W    = 22;
   localparam int FB_POS   = 32767;
   localparam int FB_NEG   = -32768;
   localparam int SAT_LIM  = 2 ** (INT_W - 1) - 1;

   // Symmetric clamp to +/-(2^21-1); the two guard bits of x hold any overflow.
   function automatic logic signed [INT_W-1:0] sat22(input logic signed [INT_W+1:0] x);
      if (x > SAT_LIM) begin
         return INT_W'(SAT_LIM);
      end else if (x < -SAT_LIM) begin
         return INT_W'(-SAT_LIM);
      end else begin
         return x[INT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/sigma_delta_dac_integrator.sv
// sdm_integrator: saturating INT_W accumulator with enable and synchronous reset.
module sdm_integrator
   import sigma_delta_dac_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en_i,
   input  logic signed [INT_W:0]   delta_i,
   output logic signed [INT_W-1:0] acc_next_o
);

   logic signed [INT_W-1:0] acc_q;
   logic signed [INT_W+1:0] sum;

   assign sum        = {{2{acc_q[INT_W-1]}}, acc_q} + {delta_i[INT_W], delta_i};
   assign acc_next_o = sat22(sum);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_next_o;
      end
   end

endmodule

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: soft-muted, gap-watched 1-bit sigma-delta output stage.
// Define SIGMA_DELTA_DAC_SECOND_ORDER_EN to build the second-order loop.
module sigma_delta_dac
   import sigma_delta_dac_pkg::*;
#(
   parameter int CLK_DIV = 1,
   parameter int MAX_GAP = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] sample_in,
   input  logic               sample_stb,
   input  logic               mute,
   output logic               dac_out,
   output logic               muted,
   output logic               underrun
);

   localparam logic [8:0]  GAIN_FULL = 9'(GAIN_MAX);
   localparam logic [19:0] GAP_SAT   = 20'(MAX_GAP);

   state_e                  state_q, state_d, dir_state;
   logic [8:0]              gain_q, gain_d;
   logic signed [15:0]      hold_q, hold_d;
   logic signed [15:0]      scaled_q, scaled_d;
   logic signed [23:0]      product;
   logic [15:0]             div_q, div_d;
   logic [19:0]             gap_q, gap_d;
   logic                    dac_q, dac_d;
   logic                    tick;
   logic signed [INT_W:0]   fb;
   logic signed [INT_W-1:0] i1_next;

   // The step direction comes from the post-transition state, so a strobe that
   // coincides with a mute edge already ramps the new way.
   // NOTE: every always_comb output is defaulted first so no path infers a latch.
   always_comb begin
      dir_state = state_q;
      gain_d    = gain_q;
      case (state_q)
         MUTED:     if (!mute) dir_state = RAMP_UP;
         RAMP_UP:   if (mute)  dir_state = RAMP_DOWN;
         PLAY:      if (mute)  dir_state = RAMP_DOWN;
         RAMP_DOWN: if (!mute) dir_state = RAMP_UP;
         default:   dir_state = MUTED;
      endcase
      if (sample_stb && dir_state == RAMP_UP && gain_q != GAIN_FULL) begin
         gain_d = gain_q + 9'd1;
      end else if (sample_stb && dir_state == RAMP_DOWN && gain_q != 9'd0) begin
         gain_d = gain_q - 9'd1;
      end
      state_d = dir_state;
      if (dir_state == RAMP_UP && gain_d == GAIN_FULL) begin
         state_d = PLAY;
      end else if (dir_state == RAMP_DOWN && gain_d == 9'd0) begin
         state_d = MUTED;
      end
   end

   // gain <= 256 keeps the product inside 24 signed bits.
   assign product  = 24'(hold_q) * 24'($signed({1'b0, gain_q}));
   assign scaled_d = 16'(product >>> 8);
   assign hold_d   = sample_stb ? sample_in : hold_q;

   assign tick  = (CLK_DIV == 1) || (div_q == 16'(CLK_DIV - 1));
   assign div_d = tick ? 16'd0 : div_q + 16'd1;

   assign gap_d = sample_stb ? 20'd0 : (gap_q == GAP_SAT) ? gap_q : gap_q + 20'd1;

   assign fb = dac_q ? (INT_W+1)'(FB_POS) : (INT_W+1)'(FB_NEG);

   sdm_integrator u_int1 (
      .clk        (clk),
      .reset      (reset),
      .en_i       (tick),
      .delta_i    ((INT_W+1)'(scaled_q) - fb),
      .acc_next_o (i1_next)
   );

`ifdef SIGMA_DELTA_DAC_SECOND_ORDER_EN
   logic signed [INT_W-1:0] i2_next;

   // Fed from i1's value after this tick so the loop latency stays one edge.
   sdm_integrator u_int2 (
      .clk        (clk),
      .reset      (reset),
      .en_i       (tick),
      .delta_i    ((INT_W+1)'(i1_next) - fb),
      .acc_next_o (i2_next)
   );

   assign dac_d = tick ? ~i2_next[INT_W-1] : dac_q;
`else
   assign dac_d = tick ? ~i1_next[INT_W-1] : dac_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= MUTED;
         gain_q   <= '0;
         hold_q   <= '0;
         scaled_q <= '0;
         div_q    <= '0;
         gap_q    <= '0;
         dac_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gain_q   <= gain_d;
         hold_q   <= hold_d;
         scaled_q <= scaled_d;
         div_q    <= div_d;
         gap_q    <= gap_d;
         dac_q    <= dac_d;
      end
   end

   assign dac_out  = dac_q;
   assign muted    = (state_q == MUTED);
   assign underrun = (gap_q == GAP_SAT);

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Scoreboard bench for sigma_delta_dac: two DUTs (CLK_DIV 1 and 4) against a cycle-level integer model.
module tb_sigma_delta_dac;

   localparam int GAP = 64;
   localparam int LIM = 2097151;
`ifdef SIGMA_DELTA_DAC_SECOND_ORDER_EN
   localparam bit ORDER2 = 1'b1;
`else
   localparam bit ORDER2 = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [15:0] sample_in = '0;
   logic               sample_stb = 1'b0;
   logic               mute = 1'b0;
   logic               dac1, muted1, under1;
   logic               dac4, muted4, under4;

   always #5 clk = ~clk;

   sigma_delta_dac #(.CLK_DIV(1), .MAX_GAP(GAP)) dut1 (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_stb(sample_stb),
      .mute(mute), .dac_out(dac1), .muted(muted1), .underrun(under1)
   );

   sigma_delta_dac #(.CLK_DIV(4), .MAX_GAP(GAP)) dut4 (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_stb(sample_stb),
      .mute(mute), .dac_out(dac4), .muted(muted4), .underrun(under4)
   );

   typedef struct {
      bit dac1;
      bit dac4;
      bit muted;
      bit under;
      bit tick4;
   } exp_t;

   exp_t exp_q[$];
   exp_t pend;
   bit   have_pend = 1'b0;
   bit   seen_tick4 = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference model: gain is a clamped strobe counter; muted means "mute held and gain at 0".
   int m_hold, m_gain, m_scaled, m_gap, m_div;
   int m_i1[2], m_i2[2];
   bit m_dac[2];
   bit m_muted, m_tick4;

   function automatic int sat(input int x);
      if (x > LIM)  return LIM;
      if (x < -LIM) return -LIM;
      return x;
   endfunction

   function automatic void model_step(input bit rst, input bit stb, input int smp, input bit mt);
      int scaled_new, a, b, fb;
      bit tk;
      if (rst) begin
         m_hold = 0; m_gain = 0; m_scaled = 0; m_gap = 0; m_div = 0;
         m_i1 = '{0, 0}; m_i2 = '{0, 0}; m_dac = '{0, 0};
         m_muted = 1'b1; m_tick4 = 1'b0;
         return;
      end
      scaled_new = (m_hold * m_gain) >>> 8;
      for (int k = 0; k < 2; k++) begin
         tk = (k == 0) ? 1'b1 : (m_div == 3);
         if (tk) begin
            fb = m_dac[k] ? 32767 : -32768;
            a  = sat(m_i1[k] + m_scaled - fb);
            b  = sat(m_i2[k] + a - fb);
            m_i1[k]  = a;
            m_i2[k]  = b;
            m_dac[k] = ORDER2 ? (b >= 0) : (a >= 0);
         end
      end
      m_tick4  = (m_div == 3);
      m_div    = m_tick4 ? 0 : m_div + 1;
      m_scaled = scaled_new;
      if (stb) begin
         m_hold = smp;
         if (mt) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
         else    m_gain = (m_gain < 256) ? m_gain + 1 : 256;
      end
      m_muted = mt && (m_gain == 0);
      m_gap   = stb ? 0 : ((m_gap < GAP) ? m_gap + 1 : GAP);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.dac1  = m_dac[0];
      e.dac4  = m_dac[1];
      e.muted = m_muted;
      e.under = (m_gap == GAP);
      e.tick4 = m_tick4;
      return e;
   endfunction

   // One clock: publish the expectation for the edge just taken, then drive the next edge.
   task automatic cycle(input bit rst, input bit stb, input int smp, input bit mt);
      @(posedge clk);
      #1;
      if (have_pend) begin
         exp_q.push_back(pend);
         seen_tick4 = pend.tick4;
      end
      reset      = rst;
      sample_stb = stb;
      sample_in  = 16'(smp);
      mute       = mt;
      model_step(rst, stb, smp, mt);
      pend      = model_out();
      have_pend = 1'b1;
   endtask

   // Monitor: pops one expectation per clock once the stimulus has published it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dac_out_div1", dac1, e.dac1);
            check("dac_out_div4", dac4, e.dac4);
            check("muted_div1", muted1, e.muted);
            check("muted_div4", muted4, e.muted);
            check("underrun_div1", under1, e.under);
            check("underrun_div4", under4, e.under);
         end
      end
   end

   task automatic density(input int smp, input bit chk_gap, output int ones1, output int rises4,
                          output int offtick);
      bit prev4;
      cycle(0, 1, smp, 0);
      repeat (64) cycle(0, 0, 0, 0);
      if (chk_gap) check("underrun_before_gap", under1, 0);
      cycle(0, 0, 0, 0);
      if (chk_gap) check("underrun_at_gap", under1, 1);
      ones1 = 0; rises4 = 0; offtick = 0;
      prev4 = dac4;
      for (int i = 0; i < 1024; i++) begin
         cycle(0, 0, 0, 0);
         ones1 += int'(dac1);
         if (dac4 && !prev4) rises4++;
         if (dac4 != prev4 && !seen_tick4) offtick++;
         prev4 = dac4;
      end
      check("underrun_during_window", under1, 1);
   endtask

   initial begin
      int ones1, rises4, offtick;
      bit mt_r;
      bit stb_r;
      int smp_r;

      model_step(1, 0, 0, 0);
      pend      = model_out();
      have_pend = 1'b1;

      // Reset held with strobes active and mute low.
      cycle(1, 1, 12345, 0);

      // Ramp up 100 strobes, then reverse on the same edge as strobe 101.
      for (int s = 0; s < 100; s++) begin
         cycle(0, 1, 16384, 0);
         repeat (9) cycle(0, 0, 0, 0);
      end
      for (int s = 0; s < 100; s++) begin
         cycle(0, 1, 16384, 1);
         repeat (9) cycle(0, 0, 0, 1);
         if (s == 98) check("muted_before_last_down_step", muted1, 0);
         if (s == 99) check("muted_after_last_down_step", muted1, 1);
      end

      // Full ramp to PLAY.
      for (int s = 0; s < 256; s++) begin
         cycle(0, 1, 16384, 0);
         repeat (9) cycle(0, 0, 0, 0);
         if (s == 0) check("unmuted_after_first_strobe", muted1, 0);
      end

      density(0, 1'b1, ones1, rises4, offtick);
      check_range("density_zero_div1", ones1, 510, 514);
      check_range("toggles_zero_div4", rises4, 126, 130);
      check("offtick_changes_zero", offtick, 0);

      // Next strobe clears underrun on its capture edge.
      cycle(0, 1, 32767, 0);
      check("underrun_before_capture", under1, 1);
      cycle(0, 0, 0, 0);
      check("underrun_cleared", under1, 0);

      density(32767, 1'b0, ones1, rises4, offtick);
      check_range("density_pos_full", ones1, 1022, 1024);
      check("offtick_changes_pos", offtick, 0);

      density(-32768, 1'b0, ones1, rises4, offtick);
      check_range("density_neg_full", ones1, 0, 2);
      check("offtick_changes_neg", offtick, 0);

      // Random traffic with a long strobe gap and a mid-run reset.
      mt_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i >= 1000 && i < 1200) stb_r = 1'b0;
         else                       stb_r = ($urandom_range(3) == 0);
         if ($urandom_range(199) == 0) mt_r = ~mt_r;
         smp_r = int'($urandom_range(65535)) - 32768;
         cycle(i == 2000, stb_r, smp_r, mt_r);
      end

      @(posedge clk);
      #1;
      exp_q.push_back(pend);
      repeat (3) @(posedge clk);
      #4;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
